// File: rtl/sram_pin_responder.sv
// sram_pin_responder: pin-level model of an asynchronous SRAM chip.
// Every pin is sampled on the rising CLK edge and classified as a DESEL, IDLE,
// WRITE or READ cycle. Writes land in the array at the sampling edge. Reads
// take a snapshot of the array at the issue edge. That word then travels
// through an RD_LAT-deep pipe to SRAM_DATA_OUT_Pin. The block also keeps
// saturating read/write counters and raises a one-cycle flag when an access
// falls outside the implemented depth.
module sram_pin_responder #(
  parameter int ADDRW  = 20,
  parameter int DATAW  = 16,
  parameter int MEMW   = 10,
  parameter int RD_LAT = 2
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             SRAM_CS_Pin,
  input  logic             SRAM_OE_Pin,
  input  logic             SRAM_WR_Pin,
  input  logic [ADDRW-1:0] SRAM_ADDR_Pin,
  input  logic [DATAW-1:0] SRAM_DATA_IN_Pin,
  output logic [DATAW-1:0] SRAM_DATA_OUT_Pin,
  output logic [15:0]      rd_count,
  output logic [15:0]      wr_count,
  output logic             addr_err
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DESEL,
    ST_WRITE,
    ST_READ
  } state_t;

  state_t           state_reg, state_next;
  logic             in_range;
  logic [MEMW-1:0]  idx;
  logic             do_write, do_read, force_zero;
  logic [DATAW-1:0] issue_data;
  logic             exit_valid;
  logic [DATAW-1:0] exit_data;
  logic [DATAW-1:0] out_reg, out_next;
  logic [15:0]      rd_count_reg, wr_count_reg;
  logic             oob_reg;

  logic [DATAW-1:0] mem [2**MEMW];

  assign idx = SRAM_ADDR_Pin[MEMW-1:0];

  // Address bits above the implemented depth must be zero. A full-width array
  // has no upper bits to check.
  generate
    if (MEMW < ADDRW) begin : g_range
      assign in_range = ~|SRAM_ADDR_Pin[ADDRW-1:MEMW];
    end else begin : g_full_range
      assign in_range = 1'b1;
    end
  endgenerate

  // Classify the pins for the current edge. WR takes priority over OE.
  always_comb begin
    state_next = ST_IDLE;
    if (SRAM_CS_Pin)       state_next = ST_DESEL;
    else if (!SRAM_WR_Pin) state_next = ST_WRITE;
    else if (!SRAM_OE_Pin) state_next = ST_READ;
    do_write   = (state_next == ST_WRITE) && in_range;
    do_read    = (state_next == ST_READ);
    force_zero = (state_next == ST_DESEL) || (state_next == ST_IDLE);
  end

  // Snapshot seen by a read issued this edge. An out-of-range read carries zero.
  assign issue_data = in_range ? mem[idx] : '0;

  // Array write. The array has no reset, so it can map onto block RAM.
  always_ff @(posedge CLK) begin
    if (do_write) mem[idx] <= SRAM_DATA_IN_Pin;
  end

  // Read pipe. The output register is the final stage, so RD_LAT-1 pipe
  // registers sit in front of it.
  generate
    if (RD_LAT == 1) begin : g_lat1
      assign exit_valid = do_read;
      assign exit_data  = issue_data;
    end else begin : g_pipe
      localparam int DEPTH = RD_LAT - 1;
      logic [DEPTH-1:0] pipe_valid_reg;
      logic [DATAW-1:0] pipe_data_reg [DEPTH];

      // Valid bits are flushed by reset, so no stale word can exit afterwards.
      always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
          pipe_valid_reg <= '0;
        end else begin
          pipe_valid_reg[0] <= do_read;
          for (int i = 1; i < DEPTH; i++) pipe_valid_reg[i] <= pipe_valid_reg[i-1];
        end
      end

      // Data stages only matter when their valid bit is set, so they are not reset.
      always_ff @(posedge CLK) begin
        pipe_data_reg[0] <= issue_data;
        for (int i = 1; i < DEPTH; i++) pipe_data_reg[i] <= pipe_data_reg[i-1];
      end

      assign exit_valid = pipe_valid_reg[DEPTH-1];
      assign exit_data  = pipe_data_reg[DEPTH-1];
    end
  endgenerate

  // A word leaving the pipe always wins. Otherwise the output is zeroed by
  // DESEL or IDLE cycles and holds its value through READ and WRITE cycles.
  always_comb begin
    out_next = out_reg;
    if (exit_valid)      out_next = exit_data;
    else if (force_zero) out_next = '0;
  end

  // State, output data, saturating counters and the sampled range fault.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_reg    <= ST_IDLE;
      out_reg      <= '0;
      rd_count_reg <= '0;
      wr_count_reg <= '0;
      oob_reg      <= 1'b0;
    end else begin
      state_reg <= state_next;
      out_reg   <= out_next;
      oob_reg   <= ~in_range;
      if (do_read && (rd_count_reg != 16'hFFFF))  rd_count_reg <= rd_count_reg + 16'd1;
      if (do_write && (wr_count_reg != 16'hFFFF)) wr_count_reg <= wr_count_reg + 16'd1;
    end
  end

  // The error flag holds for exactly the one cycle after an out-of-range access.
  assign addr_err = oob_reg && ((state_reg == ST_READ) || (state_reg == ST_WRITE));

  assign SRAM_DATA_OUT_Pin = out_reg;
  assign rd_count          = rd_count_reg;
  assign wr_count          = wr_count_reg;

endmodule

// File: tb/tb_sram_pin_responder.sv
// Directed bench for sram_pin_responder (ADDRW=20, DATAW=16, MEMW=10, RD_LAT=2).
// Pins are driven before a rising edge, and outputs are sampled 1 time unit after it.
module tb_sram_pin_responder;

  logic        CLK;
  logic        RSTn;
  logic        cs, oe, wr;
  logic [19:0] addr;
  logic [15:0] din;
  logic [15:0] dout;
  logic [15:0] rd_count, wr_count;
  logic        addr_err;

  int n_cmp = 0;
  int n_bad = 0;

  sram_pin_responder #(
    .ADDRW(20), .DATAW(16), .MEMW(10), .RD_LAT(2)
  ) dut (
    .CLK              (CLK),
    .RSTn             (RSTn),
    .SRAM_CS_Pin      (cs),
    .SRAM_OE_Pin      (oe),
    .SRAM_WR_Pin      (wr),
    .SRAM_ADDR_Pin    (addr),
    .SRAM_DATA_IN_Pin (din),
    .SRAM_DATA_OUT_Pin(dout),
    .rd_count         (rd_count),
    .wr_count         (wr_count),
    .addr_err         (addr_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_pins(input logic c, input logic o, input logic w,
                          input logic [19:0] a, input logic [15:0] d);
    cs = c; oe = o; wr = w; addr = a; din = d;
  endtask

  task automatic do_cycle(input string what);
    @(posedge CLK);
    #1;
    $display("[%0t] %s -> out=%h rd=%0d wr=%0d err=%b", $time, what, dout, rd_count, wr_count, addr_err);
  endtask

  task automatic wr_cyc(input logic [19:0] a, input logic [15:0] d);
    set_pins(1'b0, 1'b1, 1'b0, a, d);
    do_cycle($sformatf("WRITE a=%05h d=%04h", a, d));
  endtask

  task automatic rd_cyc(input logic [19:0] a);
    set_pins(1'b0, 1'b0, 1'b1, a, 16'h0);
    do_cycle($sformatf("READ  a=%05h", a));
  endtask

  task automatic idle_cyc();
    set_pins(1'b0, 1'b1, 1'b1, 20'h0, 16'h0);
    do_cycle("IDLE");
  endtask

  task automatic desel_cyc();
    set_pins(1'b1, 1'b1, 1'b1, 20'h0, 16'h0);
    do_cycle("DESEL");
  endtask

  initial begin
    RSTn = 1'b0;
    set_pins(1'b1, 1'b1, 1'b1, 20'h0, 16'h0);
    repeat (2) @(posedge CLK);
    #1;
    check_val("reset_out", dout, 16'h0);
    check_val("reset_rd", rd_count, 16'h0);
    check_val("reset_wr", wr_count, 16'h0);
    check_val("reset_err", addr_err, 1'b0);
    @(negedge CLK);
    RSTn = 1'b1;

    // 1: single write then read, two-cycle latency, then IDLE zeroes the output
    wr_cyc(20'h00010, 16'hA5A5);
    check_val("t1_wr_count", wr_count, 16'd1);
    rd_cyc(20'h00010);
    check_val("t1_rd_count", rd_count, 16'd1);
    check_val("t1_out_early", dout, 16'h0);
    idle_cyc();
    check_val("t1_out", dout, 16'hA5A5);
    idle_cyc();
    check_val("t1_idle_zero", dout, 16'h0);

    // 2: back-to-back reads, then a write cycle holds the output
    wr_cyc(20'h1, 16'h1111);
    wr_cyc(20'h2, 16'h2222);
    wr_cyc(20'h3, 16'h3333);
    check_val("t2_wr_count", wr_count, 16'd4);
    rd_cyc(20'h1);
    check_val("t2_out0", dout, 16'h0);
    rd_cyc(20'h2);
    check_val("t2_out1", dout, 16'h1111);
    rd_cyc(20'h3);
    check_val("t2_out2", dout, 16'h2222);
    idle_cyc();
    check_val("t2_out3", dout, 16'h3333);
    check_val("t2_rd_count", rd_count, 16'd4);
    wr_cyc(20'h4, 16'h4444);
    check_val("t2_hold", dout, 16'h3333);

    // 3: out-of-range write and read (0x80000 aliases index 0 if unchecked)
    wr_cyc(20'h00000, 16'h0F0F);
    check_val("t3_wr_count_a", wr_count, 16'd6);
    wr_cyc(20'h80000, 16'hBEEF);
    check_val("t3_err_wr", addr_err, 1'b1);
    check_val("t3_wr_count_b", wr_count, 16'd6);
    rd_cyc(20'h00000);
    check_val("t3_err_clear", addr_err, 1'b0);
    rd_cyc(20'h80000);
    check_val("t3_err_rd", addr_err, 1'b1);
    check_val("t3_rd_count", rd_count, 16'd6);
    check_val("t3_out_base", dout, 16'h0F0F);
    rd_cyc(20'h00000);
    check_val("t3_out_oob", dout, 16'h0);
    check_val("t3_err_drop", addr_err, 1'b0);
    idle_cyc();
    check_val("t3_out_base2", dout, 16'h0F0F);
    idle_cyc();

    // 4: a read snapshots old data; a later read sees the new write
    rd_cyc(20'h1);
    wr_cyc(20'h1, 16'h5555);
    check_val("t4_old", dout, 16'h1111);
    rd_cyc(20'h1);
    check_val("t4_hold", dout, 16'h1111);
    idle_cyc();
    check_val("t4_new", dout, 16'h5555);
    check_val("t4_rd_count", rd_count, 16'd9);

    // 5: reset while reads are in flight flushes the pipe
    rd_cyc(20'h2);
    rd_cyc(20'h3);
    check_val("t5_pre", dout, 16'h2222);
    RSTn = 1'b0;
    #1;
    check_val("t5_out_rst", dout, 16'h0);
    check_val("t5_rd_rst", rd_count, 16'h0);
    check_val("t5_wr_rst", wr_count, 16'h0);
    set_pins(1'b0, 1'b0, 1'b1, 20'h4, 16'h0);
    @(posedge CLK);
    #1;
    RSTn = 1'b1;
    do_cycle("READ  a=00004 (first edge after reset)");
    check_val("t5_no_stale", dout, 16'h0);
    check_val("t5_rd_count", rd_count, 16'd1);
    idle_cyc();
    check_val("t5_after", dout, 16'h4444);

    // 6: write counter saturation, then DESEL zeroes the output
    wr_cyc(20'h7, 16'h7777);
    repeat (16'hFFFD) @(posedge CLK);
    #1;
    $display("[%0t] WRITE a=00007 x%0d (preload) -> wr=%0h", $time, 16'hFFFD, wr_count);
    check_val("t6_preload", wr_count, 16'hFFFE);
    wr_cyc(20'h7, 16'h7777);
    check_val("t6_sat", wr_count, 16'hFFFF);
    wr_cyc(20'h7, 16'h7777);
    wr_cyc(20'h7, 16'h7777);
    check_val("t6_sat_hold", wr_count, 16'hFFFF);
    check_val("t6_out_held", dout, 16'h4444);
    desel_cyc();
    check_val("t6_desel_zero", dout, 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
